// File: rtl/hitmap_serializer.sv
// Latches one crate hit map (header + 38 rows) and streams it out as header, rows, trailer
// over valid/ready. Maps arriving while a frame is in flight are dropped and counted.
module hitmap_serializer #(
    parameter bit SKIP_EMPTY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [37:0] in_header,
    input  logic [37:0] in_row00, input logic [37:0] in_row01, input logic [37:0] in_row02,
    input  logic [37:0] in_row03, input logic [37:0] in_row04, input logic [37:0] in_row05,
    input  logic [37:0] in_row06, input logic [37:0] in_row07, input logic [37:0] in_row08,
    input  logic [37:0] in_row09, input logic [37:0] in_row10, input logic [37:0] in_row11,
    input  logic [37:0] in_row12, input logic [37:0] in_row13, input logic [37:0] in_row14,
    input  logic [37:0] in_row15, input logic [37:0] in_row16, input logic [37:0] in_row17,
    input  logic [37:0] in_row18, input logic [37:0] in_row19, input logic [37:0] in_row20,
    input  logic [37:0] in_row21, input logic [37:0] in_row22, input logic [37:0] in_row23,
    input  logic [37:0] in_row24, input logic [37:0] in_row25, input logic [37:0] in_row26,
    input  logic [37:0] in_row27, input logic [37:0] in_row28, input logic [37:0] in_row29,
    input  logic [37:0] in_row30, input logic [37:0] in_row31, input logic [37:0] in_row32,
    input  logic [37:0] in_row33, input logic [37:0] in_row34, input logic [37:0] in_row35,
    input  logic [37:0] in_row36, input logic [37:0] in_row37,
    output logic [37:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic [5:0]  out_row,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {IDLE, HDR, ROWS, TRL} state_t;

    state_t      state;
    logic [5:0]  r;
    logic [10:0] hit_acc;
    logic [37:0] rows_q  [38];
    logic [37:0] in_rows [38];

    logic        hdr_ok;
    logic [10:0] acc_nxt;
    logic [5:0]  nidx;
    logic [37:0] nrow;
    logic        nskip;

    function automatic logic [5:0] popcnt(input logic [37:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 38; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    assign in_rows = '{in_row00, in_row01, in_row02, in_row03, in_row04, in_row05, in_row06,
                       in_row07, in_row08, in_row09, in_row10, in_row11, in_row12, in_row13,
                       in_row14, in_row15, in_row16, in_row17, in_row18, in_row19, in_row20,
                       in_row21, in_row22, in_row23, in_row24, in_row25, in_row26, in_row27,
                       in_row28, in_row29, in_row30, in_row31, in_row32, in_row33, in_row34,
                       in_row35, in_row36, in_row37};

    assign hdr_ok = in_header[37] && (in_header[15:0] == 16'hAAAA);

    // Next row to present: row 0 when leaving HDR, otherwise r+1 (unused once r reaches 37).
    always_comb begin
        acc_nxt = hit_acc + {5'd0, popcnt(rows_q[r])};
        nidx    = (state == HDR || r == 6'd37) ? 6'd0 : r + 6'd1;
        nrow    = rows_q[nidx];
        nskip   = SKIP_EMPTY && (nrow == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            hit_acc   <= '0;
            for (int i = 0; i < 38; i++) rows_q[i] <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_row   <= '0;
            busy      <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (hdr_ok && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

            case (state)
                IDLE: if (hdr_ok) begin
                    rows_q    <= in_rows;
                    hit_acc   <= '0;
                    r         <= '0;
                    state     <= HDR;
                    busy      <= 1'b1;
                    out_valid <= 1'b1;
                    out_sof   <= 1'b1;
                    out_eof   <= 1'b0;
                    out_row   <= '0;
                    out_data  <= in_header;
                end
                HDR: if (out_ready) begin
                    state     <= ROWS;
                    out_sof   <= 1'b0;
                    out_valid <= !nskip;
                    out_data  <= nskip ? '0 : nrow;
                    out_row   <= nskip ? '0 : nidx;
                end
                // A row completes on its handshake, or unconditionally on its skip cycle.
                ROWS: if (!out_valid || out_ready) begin
                    hit_acc <= acc_nxt;
                    if (r == 6'd37) begin
                        state     <= TRL;
                        out_valid <= 1'b1;
                        out_eof   <= 1'b1;
                        out_row   <= '0;
                        out_data  <= {1'b0, 10'd0, acc_nxt, 16'h5555};
                    end else begin
                        r         <= nidx;
                        out_valid <= !nskip;
                        out_data  <= nskip ? '0 : nrow;
                        out_row   <= nskip ? '0 : nidx;
                    end
                end
                TRL: if (out_ready) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_eof   <= 1'b0;
                    out_data  <= '0;
                    out_row   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hitmap_serializer.sv
// Randomized bench for hitmap_serializer: two instances (SKIP_EMPTY 0 and 1) share stimulus
// and are each compared against a per-frame expected word list built from the captured map.
module tb_hitmap_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [37:0] in_header = '0;
    logic [37:0] rows_in [38];
    logic        out_ready = 1'b0;

    logic [37:0] od   [2];
    logic        ov   [2];
    logic        osof [2];
    logic        oeof [2];
    logic [5:0]  orow [2];
    logic        obusy[2];
    logic [7:0]  odrop[2];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [45:0] expw [2][40];
    int          expn [2];
    int          expi [2];
    logic        mbusy[2];
    int          mdrop[2];
    logic        full_rdy[2];
    int          cap_cyc[2];
    logic        prev_stall[2];
    logic [45:0] prev_word[2];

    always #5 clk = ~clk;

    hitmap_serializer #(.SKIP_EMPTY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_header(in_header),
        .in_row00(rows_in[0]),  .in_row01(rows_in[1]),  .in_row02(rows_in[2]),  .in_row03(rows_in[3]),
        .in_row04(rows_in[4]),  .in_row05(rows_in[5]),  .in_row06(rows_in[6]),  .in_row07(rows_in[7]),
        .in_row08(rows_in[8]),  .in_row09(rows_in[9]),  .in_row10(rows_in[10]), .in_row11(rows_in[11]),
        .in_row12(rows_in[12]), .in_row13(rows_in[13]), .in_row14(rows_in[14]), .in_row15(rows_in[15]),
        .in_row16(rows_in[16]), .in_row17(rows_in[17]), .in_row18(rows_in[18]), .in_row19(rows_in[19]),
        .in_row20(rows_in[20]), .in_row21(rows_in[21]), .in_row22(rows_in[22]), .in_row23(rows_in[23]),
        .in_row24(rows_in[24]), .in_row25(rows_in[25]), .in_row26(rows_in[26]), .in_row27(rows_in[27]),
        .in_row28(rows_in[28]), .in_row29(rows_in[29]), .in_row30(rows_in[30]), .in_row31(rows_in[31]),
        .in_row32(rows_in[32]), .in_row33(rows_in[33]), .in_row34(rows_in[34]), .in_row35(rows_in[35]),
        .in_row36(rows_in[36]), .in_row37(rows_in[37]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_sof(osof[0]),
        .out_eof(oeof[0]), .out_row(orow[0]), .busy(obusy[0]), .drop_cnt(odrop[0])
    );

    hitmap_serializer #(.SKIP_EMPTY(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_header(in_header),
        .in_row00(rows_in[0]),  .in_row01(rows_in[1]),  .in_row02(rows_in[2]),  .in_row03(rows_in[3]),
        .in_row04(rows_in[4]),  .in_row05(rows_in[5]),  .in_row06(rows_in[6]),  .in_row07(rows_in[7]),
        .in_row08(rows_in[8]),  .in_row09(rows_in[9]),  .in_row10(rows_in[10]), .in_row11(rows_in[11]),
        .in_row12(rows_in[12]), .in_row13(rows_in[13]), .in_row14(rows_in[14]), .in_row15(rows_in[15]),
        .in_row16(rows_in[16]), .in_row17(rows_in[17]), .in_row18(rows_in[18]), .in_row19(rows_in[19]),
        .in_row20(rows_in[20]), .in_row21(rows_in[21]), .in_row22(rows_in[22]), .in_row23(rows_in[23]),
        .in_row24(rows_in[24]), .in_row25(rows_in[25]), .in_row26(rows_in[26]), .in_row27(rows_in[27]),
        .in_row28(rows_in[28]), .in_row29(rows_in[29]), .in_row30(rows_in[30]), .in_row31(rows_in[31]),
        .in_row32(rows_in[32]), .in_row33(rows_in[33]), .in_row34(rows_in[34]), .in_row35(rows_in[35]),
        .in_row36(rows_in[36]), .in_row37(rows_in[37]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_sof(osof[1]),
        .out_eof(oeof[1]), .out_row(orow[1]), .busy(obusy[1]), .drop_cnt(odrop[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Expected frame: header, every row (or only non-zero rows when skipping), trailer with hit total.
    task automatic build(input int d);
        int n;
        int cnt;
        cnt = 0;
        expw[d][0] = {2'b10, 6'd0, in_header};
        n = 1;
        for (int k = 0; k < 38; k++) begin
            cnt += $countones(rows_in[k]);
            if (d == 0 || rows_in[k] != '0) begin
                expw[d][n] = {2'b00, 6'(k), rows_in[k]};
                n++;
            end
        end
        expw[d][n] = {2'b01, 6'd0, 1'b0, 10'd0, 11'(cnt), 16'h5555};
        expn[d] = n + 1;
        expi[d] = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            logic [45:0] cur;
            cur = {osof[d], oeof[d], orow[d], od[d]};
            if (rst) begin
                mbusy[d] = 1'b0; mdrop[d] = 0; expn[d] = 0; expi[d] = 0;
                prev_stall[d] = 1'b0; full_rdy[d] = 1'b0;
            end else begin
                chk("busy", 64'(obusy[d]), 64'(mbusy[d]));
                chk("drop_cnt", 64'(odrop[d]), 64'(mdrop[d]));
                if (d == 0) chk("valid", 64'(ov[d]), 64'(mbusy[d]));
                if (prev_stall[d]) begin
                    chk("hold_valid", 64'(ov[d]), 64'd1);
                    chk("hold_word", 64'(cur), 64'(prev_word[d]));
                end
                if (!ov[d]) chk("idle_zero", 64'(cur), 64'd0);
                if (mbusy[d] && !out_ready) full_rdy[d] = 1'b0;
                if (in_header[37] && in_header[15:0] == 16'hAAAA) begin
                    if (!mbusy[d]) begin
                        build(d);
                        mbusy[d] = 1'b1; full_rdy[d] = 1'b1; cap_cyc[d] = cyc;
                    end else if (mdrop[d] < 255) mdrop[d]++;
                end
                if (ov[d] && out_ready) begin
                    if (expi[d] < expn[d]) begin
                        chk($sformatf("word%0d_%0d", d, expi[d]), 64'(cur), 64'(expw[d][expi[d]]));
                        expi[d]++;
                        if (expi[d] == expn[d]) begin
                            mbusy[d] = 1'b0;
                            if (full_rdy[d]) chk("frame_len", 64'(cyc - cap_cyc[d]), 64'd40);
                        end
                    end else chk("extra_word", 64'(cur), 64'd0);
                end
                prev_stall[d] = ov[d] && !out_ready;
                prev_word[d]  = cur;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_map();
        for (int k = 0; k < 38; k++)
            rows_in[k] = ($urandom % 2 == 0) ? 38'd0
                       : {$urandom, $urandom} & (($urandom % 2 == 0) ? 38'h3F_FFFF_FFFF : 38'h0_0000_0C11);
    endtask

    task automatic put_map(input logic [37:0] h);
        in_header = h;
        tick();
        in_header = '0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((mbusy[0] || mbusy[1]) && k < 3000) begin
            tick();
            k++;
        end
        chk("idle_wait", 64'(mbusy[0] | mbusy[1]), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [37:0] rand_hdr();
        return {1'b1, 21'($urandom), 16'hAAAA};
    endfunction

    initial begin
        for (int k = 0; k < 38; k++) rows_in[k] = '0;
        do_reset();
        chk("reset_data", 64'(od[0]), 64'd0);
        chk("reset_busy", 64'(obusy[1]), 64'd0);

        // Directed map, full throughput
        out_ready = 1'b1;
        rows_in[7]  = 38'h1;
        rows_in[16] = 38'h3F_FFFF_FFFF;
        put_map({1'b1, 11'h100, 10'h08, 16'hAAAA});
        wait_idle();

        // Same map under 1,0,0 backpressure
        put_map({1'b1, 11'h100, 10'h08, 16'hAAAA});
        for (int i = 0; i < 400 && (mbusy[0] || mbusy[1]); i++) begin
            out_ready = (i % 3 == 0);
            tick();
        end
        out_ready = 1'b1;
        wait_idle();

        // Drops at T+5 and in the trailer-handshake cycle, then capture at T+41
        do_reset();
        rand_map();
        put_map(rand_hdr());
        repeat (4) tick();
        put_map(rand_hdr());
        repeat (34) tick();
        put_map(rand_hdr());
        chk("drop_two", 64'(odrop[0]), 64'd2);
        chk("idle_after_trl", 64'(obusy[0]), 64'd0);
        rand_map();
        put_map(rand_hdr());
        chk("recapture", 64'(obusy[0]), 64'd1);
        wait_idle();

        // Random maps, random readiness, random header injection
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom % 4 != 0);
            if ($urandom % 40 == 0) begin
                rand_map();
                in_header = rand_hdr();
            end else in_header = '0;
            tick();
        end
        in_header = '0;
        out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of the rows, then a fresh frame
        rand_map();
        put_map(rand_hdr());
        repeat (21) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("abort_valid", 64'(ov[0]), 64'd0);
        chk("abort_drop", 64'(odrop[1]), 64'd0);
        rand_map();
        put_map(rand_hdr());
        wait_idle();

        // Drop counter saturation while the frame is stalled on its header
        out_ready = 1'b0;
        rand_map();
        in_header = rand_hdr();
        repeat (301) tick();
        in_header = '0;
        chk("drop_sat0", 64'(odrop[0]), 64'd255);
        chk("drop_sat1", 64'(odrop[1]), 64'd255);
        out_ready = 1'b1;
        wait_idle();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
